msrv32_trap_controller: RTL and testbench

//  Machine-mode trap sequencer for the msrv32 core. Sits beside the decoder and consumes its illegal/misaligned flags,
//  the system-instruction fields and the interrupt pending/enable bits. Decides, one cycle ahead, whether the pipeline

---
 rtl/msrv32_pkg.sv | 32 +++
 rtl/msrv32_trap_cause_encoder.sv | 82 ++++++++
 rtl/msrv32_trap_controller.sv | 144 ++++++++++++++
 tb/tb_msrv32_trap_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 trap controller: FSM states, PC-select codes,
// mcause codes and the system-instruction fields used to spot ecall/ebreak/mret.
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } state_t;

  localparam logic [1:0] PC_SRC_BOOT        = 2'b00;
  localparam logic [1:0] PC_SRC_NEXT        = 2'b01;
  localparam logic [1:0] PC_SRC_EPC         = 2'b10;
  localparam logic [1:0] PC_SRC_TRAP_VECTOR = 2'b11;

  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
  localparam logic [3:0] CAUSE_M_SW_INT         = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER_INT      = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT_INT        = 4'd11;

  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
  localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
  localparam logic [4:0] RS2_MRET      = 5'b00010;
  localparam logic [4:0] RS2_EBREAK    = 5'b00001;

endpackage

// File: rtl/msrv32_trap_cause_encoder.sv
// Combinational priority encoder: picks the highest-priority exception, then mret,
// then the highest-priority enabled interrupt, and reports the resulting trap code.
module msrv32_trap_cause_encoder
  import msrv32_pkg::*;
#(
  parameter int CAUSE_W = 4
) (
  input  logic               illegal_instr,
  input  logic               misaligned_instr,
  input  logic               misaligned_load,
  input  logic               misaligned_store,
  input  logic [4:0]         opcode_6_to_2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [4:0]         rs1_addr,
  input  logic [4:0]         rs2_addr,
  input  logic [4:0]         rd_addr,
  input  logic               mie,
  input  logic               meie,
  input  logic               mtie,
  input  logic               msie,
  input  logic               meip,
  input  logic               mtip,
  input  logic               msip,
  output logic               take,
  output logic               ret,
  output logic               i_or_e,
  output logic [CAUSE_W-1:0] cause,
  output logic               misaligned
);

  logic is_system;
  logic is_ecall;
  logic is_ebreak;
  logic is_mret;

  assign is_system = (opcode_6_to_2 == OPCODE_SYSTEM) && (funct3 == 3'b000) &&
                     (rs1_addr == 5'd0) && (rd_addr == 5'd0);
  assign is_ecall  = is_system && (funct7 == 7'd0) && (rs2_addr == 5'd0);
  assign is_ebreak = is_system && (funct7 == 7'd0) && (rs2_addr == RS2_EBREAK);
  assign is_mret   = is_system && (funct7 == FUNCT7_MRET) && (rs2_addr == RS2_MRET);

  // Exceptions outrank mret, and mret outranks any pending interrupt.
  always_comb begin
    take       = 1'b1;
    ret        = 1'b0;
    i_or_e     = 1'b0;
    misaligned = 1'b0;
    cause      = '0;
    if (misaligned_instr) begin
      cause      = CAUSE_W'(CAUSE_INSTR_MISALIGNED);
      misaligned = 1'b1;
    end else if (illegal_instr) begin
      cause = CAUSE_W'(CAUSE_ILLEGAL_INSTR);
    end else if (is_ebreak) begin
      cause = CAUSE_W'(CAUSE_BREAKPOINT);
    end else if (is_ecall) begin
      cause = CAUSE_W'(CAUSE_ECALL_M);
    end else if (misaligned_load) begin
      cause      = CAUSE_W'(CAUSE_LOAD_MISALIGNED);
      misaligned = 1'b1;
    end else if (misaligned_store) begin
      cause      = CAUSE_W'(CAUSE_STORE_MISALIGNED);
      misaligned = 1'b1;
    end else if (is_mret) begin
      take = 1'b0;
      ret  = 1'b1;
    end else if (mie && meie && meip) begin
      i_or_e = 1'b1;
      cause  = CAUSE_W'(CAUSE_M_EXT_INT);
    end else if (mie && msie && msip) begin
      i_or_e = 1'b1;
      cause  = CAUSE_W'(CAUSE_M_SW_INT);
    end else if (mie && mtie && mtip) begin
      i_or_e = 1'b1;
      cause  = CAUSE_W'(CAUSE_M_TIMER_INT);
    end else begin
      take = 1'b0;
    end
  end

endmodule

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap sequencer: decides one cycle ahead whether the core continues,
// enters a trap or returns via mret, and drives PC-select, flush and CSR strobes.
module msrv32_trap_controller
  import msrv32_pkg::*;
#(
  parameter int CAUSE_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               illegal_instr_in,
  input  logic               misaligned_instr_in,
  input  logic               misaligned_load_in,
  input  logic               misaligned_store_in,
  input  logic [4:0]         opcode_6_to_2_in,
  input  logic [2:0]         funct3_in,
  input  logic [6:0]         funct7_in,
  input  logic [4:0]         rs1_addr_in,
  input  logic [4:0]         rs2_addr_in,
  input  logic [4:0]         rd_addr_in,
  input  logic               mie_in,
  input  logic               meie_in,
  input  logic               mtie_in,
  input  logic               msie_in,
  input  logic               meip_in,
  input  logic               mtip_in,
  input  logic               msip_in,
  output logic [1:0]         pc_src_out,
  output logic               flush_out,
  output logic               trap_taken_out,
  output logic               i_or_e_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic               set_cause_out,
  output logic               set_epc_out,
  output logic               mie_clear_out,
  output logic               mie_set_out,
  output logic               instret_inc_out,
  output logic               misaligned_exception_out
);

  state_t             state;
  logic               take;
  logic               ret;
  logic               next_i_or_e;
  logic [CAUSE_W-1:0] next_cause;
  logic               next_misaligned;
  logic               i_or_e_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               misaligned_q;

  msrv32_trap_cause_encoder #(.CAUSE_W(CAUSE_W)) u_encoder (
    .illegal_instr    (illegal_instr_in),
    .misaligned_instr (misaligned_instr_in),
    .misaligned_load  (misaligned_load_in),
    .misaligned_store (misaligned_store_in),
    .opcode_6_to_2    (opcode_6_to_2_in),
    .funct3           (funct3_in),
    .funct7           (funct7_in),
    .rs1_addr         (rs1_addr_in),
    .rs2_addr         (rs2_addr_in),
    .rd_addr          (rd_addr_in),
    .mie              (mie_in),
    .meie             (meie_in),
    .mtie             (mtie_in),
    .msie             (msie_in),
    .meip             (meip_in),
    .mtip             (mtip_in),
    .msip             (msip_in),
    .take             (take),
    .ret              (ret),
    .i_or_e           (next_i_or_e),
    .cause            (next_cause),
    .misaligned       (next_misaligned)
  );

  // Trap inputs only matter in OPERATING; the other states carry a flushed instruction.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_RESET;
      i_or_e_q     <= 1'b0;
      cause_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      case (state)
        ST_RESET: state <= ST_OPERATING;
        ST_OPERATING: begin
          if (take) begin
            state        <= ST_TRAP_TAKEN;
            i_or_e_q     <= next_i_or_e;
            cause_q      <= next_cause;
            misaligned_q <= next_misaligned;
          end else if (ret) begin
            state <= ST_TRAP_RETURN;
          end
        end
        ST_TRAP_TAKEN:  state <= ST_OPERATING;
        ST_TRAP_RETURN: state <= ST_OPERATING;
        default:        state <= ST_RESET;
      endcase
    end
  end

  always_comb begin
    pc_src_out      = PC_SRC_BOOT;
    flush_out       = 1'b0;
    trap_taken_out  = 1'b0;
    set_cause_out   = 1'b0;
    set_epc_out     = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    case (state)
      ST_RESET: begin
        pc_src_out = PC_SRC_BOOT;
        flush_out  = 1'b1;
      end
      ST_OPERATING: begin
        pc_src_out      = PC_SRC_NEXT;
        instret_inc_out = !(take || ret);
      end
      ST_TRAP_TAKEN: begin
        pc_src_out     = PC_SRC_TRAP_VECTOR;
        flush_out      = 1'b1;
        trap_taken_out = 1'b1;
        set_cause_out  = 1'b1;
        set_epc_out    = 1'b1;
        mie_clear_out  = 1'b1;
      end
      ST_TRAP_RETURN: begin
        pc_src_out  = PC_SRC_EPC;
        flush_out   = 1'b1;
        mie_set_out = 1'b1;
      end
      default: begin
        pc_src_out = PC_SRC_BOOT;
        flush_out  = 1'b1;
      end
    endcase
  end

  assign i_or_e_out               = i_or_e_q;
  assign cause_out                = cause_q;
  assign misaligned_exception_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// Randomized bench for msrv32_trap_controller: a cycle-level behavioural model
// predicts every output each cycle from the trap rules and prioritised cause lists.
module tb_msrv32_trap_controller;

  localparam int PH_RESET  = 0;
  localparam int PH_RUN    = 1;
  localparam int PH_TRAP   = 2;
  localparam int PH_RETURN = 3;

  logic       clk;
  logic       rst_n;
  logic       illegal_instr, misaligned_instr, misaligned_load, misaligned_store;
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;
  logic       mie, meie, mtie, msie, meip, mtip, msip;
  logic [1:0] pc_src;
  logic       flush, trap_taken, i_or_e, set_cause, set_epc;
  logic       mie_clear, mie_set, instret_inc, misaligned_exc;
  logic [3:0] cause;

  int assertCount = 0;
  int failCount   = 0;

  int model_phase;
  int model_cause;
  int model_i_or_e;
  int model_misaligned;

  msrv32_trap_controller #(.CAUSE_W(4)) dut (
    .clk_in                   (clk),
    .rst_n_in                 (rst_n),
    .illegal_instr_in         (illegal_instr),
    .misaligned_instr_in      (misaligned_instr),
    .misaligned_load_in       (misaligned_load),
    .misaligned_store_in      (misaligned_store),
    .opcode_6_to_2_in         (opcode),
    .funct3_in                (funct3),
    .funct7_in                (funct7),
    .rs1_addr_in              (rs1),
    .rs2_addr_in              (rs2),
    .rd_addr_in               (rd),
    .mie_in                   (mie),
    .meie_in                  (meie),
    .mtie_in                  (mtie),
    .msie_in                  (msie),
    .meip_in                  (meip),
    .mtip_in                  (mtip),
    .msip_in                  (msip),
    .pc_src_out               (pc_src),
    .flush_out                (flush),
    .trap_taken_out           (trap_taken),
    .i_or_e_out               (i_or_e),
    .cause_out                (cause),
    .set_cause_out            (set_cause),
    .set_epc_out              (set_epc),
    .mie_clear_out            (mie_clear),
    .mie_set_out              (mie_set),
    .instret_inc_out          (instret_inc),
    .misaligned_exception_out (misaligned_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Works out what the instruction/interrupt mix in front of the controller asks for:
  // 0 = nothing, 1 = trap (with code/kind/misaligned), 2 = mret.
  task automatic decideAction(output int action, output int code, output int kind, output int mis);
    bit sys;
    bit exc_hit[6];
    int exc_code[6];
    bit exc_mis[6];
    bit irq_hit[3];
    int irq_code[3];
    bit is_mret;
    sys = (opcode == 5'b11100) && (funct3 == 3'd0) && (rs1 == 5'd0) && (rd == 5'd0);
    exc_hit[0] = misaligned_instr;                            exc_code[0] = 0;  exc_mis[0] = 1;
    exc_hit[1] = illegal_instr;                               exc_code[1] = 2;  exc_mis[1] = 0;
    exc_hit[2] = sys && (funct7 == 7'd0) && (rs2 == 5'd1);    exc_code[2] = 3;  exc_mis[2] = 0;
    exc_hit[3] = sys && (funct7 == 7'd0) && (rs2 == 5'd0);    exc_code[3] = 11; exc_mis[3] = 0;
    exc_hit[4] = misaligned_load;                             exc_code[4] = 4;  exc_mis[4] = 1;
    exc_hit[5] = misaligned_store;                            exc_code[5] = 6;  exc_mis[5] = 1;
    is_mret = sys && (funct7 == 7'b0011000) && (rs2 == 5'd2);
    irq_hit[0] = mie & meie & meip; irq_code[0] = 11;
    irq_hit[1] = mie & msie & msip; irq_code[1] = 3;
    irq_hit[2] = mie & mtie & mtip; irq_code[2] = 7;
    action = 0; code = 0; kind = 0; mis = 0;
    for (int i = 5; i >= 0; i--)
      if (exc_hit[i]) begin action = 1; code = exc_code[i]; kind = 0; mis = int'(exc_mis[i]); end
    if (action == 0) begin
      if (is_mret) action = 2;
      else
        for (int i = 2; i >= 0; i--)
          if (irq_hit[i]) begin action = 1; code = irq_code[i]; kind = 1; mis = 0; end
    end
  endtask

  task automatic checkOutputs();
    int action, code, kind, mis;
    int exp_pc, exp_flush, exp_trap, exp_ret, exp_inst;
    decideAction(action, code, kind, mis);
    exp_trap = (model_phase == PH_TRAP) ? 1 : 0;
    exp_ret  = (model_phase == PH_RETURN) ? 1 : 0;
    exp_inst = (model_phase == PH_RUN && action == 0) ? 1 : 0;
    exp_flush = (model_phase == PH_RUN) ? 0 : 1;
    case (model_phase)
      PH_RUN:    exp_pc = 1;
      PH_TRAP:   exp_pc = 3;
      PH_RETURN: exp_pc = 2;
      default:   exp_pc = 0;
    endcase
    checkOutput("pc_src", 32'(pc_src), 32'(exp_pc));
    checkOutput("flush", 32'(flush), 32'(exp_flush));
    checkOutput("trap_taken", 32'(trap_taken), 32'(exp_trap));
    checkOutput("set_cause", 32'(set_cause), 32'(exp_trap));
    checkOutput("set_epc", 32'(set_epc), 32'(exp_trap));
    checkOutput("mie_clear", 32'(mie_clear), 32'(exp_trap));
    checkOutput("mie_set", 32'(mie_set), 32'(exp_ret));
    checkOutput("instret_inc", 32'(instret_inc), 32'(exp_inst));
    checkOutput("cause", 32'(cause), 32'(model_cause));
    checkOutput("i_or_e", 32'(i_or_e), 32'(model_i_or_e));
    checkOutput("misaligned", 32'(misaligned_exc), 32'(model_misaligned));
  endtask

  task automatic clearInputs();
    illegal_instr = 0; misaligned_instr = 0; misaligned_load = 0; misaligned_store = 0;
    opcode = 5'b01100; funct3 = 0; funct7 = 0; rs1 = 0; rs2 = 0; rd = 0;
    mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
  endtask

  task automatic startCycle();
    @(negedge clk);
    clearInputs();
  endtask

  // Checks the cycle, then advances the model across the coming rising edge.
  task automatic finishCycle(input logic rst_level);
    int action, code, kind, mis;
    rst_n = rst_level;
    if (!rst_level) begin
      model_phase = PH_RESET; model_cause = 0; model_i_or_e = 0; model_misaligned = 0;
    end
    #1;
    checkOutputs();
    if (rst_level) begin
      if (model_phase == PH_RUN) begin
        decideAction(action, code, kind, mis);
        if (action == 1) begin
          model_phase = PH_TRAP; model_cause = code; model_i_or_e = kind; model_misaligned = mis;
        end else if (action == 2) begin
          model_phase = PH_RETURN;
        end
      end else begin
        model_phase = PH_RUN;
      end
    end
  endtask

  task automatic applyStimulus();
    int kind;
    startCycle();
    illegal_instr    = ($urandom_range(0, 9) == 0);
    misaligned_instr = ($urandom_range(0, 11) == 0);
    misaligned_load  = ($urandom_range(0, 9) == 0);
    misaligned_store = ($urandom_range(0, 9) == 0);
    kind = $urandom_range(0, 6);
    case (kind)
      0: begin opcode = 5'b11100; end
      1: begin opcode = 5'b11100; rs2 = 5'd1; end
      2: begin opcode = 5'b11100; funct7 = 7'b0011000; rs2 = 5'd2; end
      3: begin
        opcode = 5'b11100; funct3 = 3'($urandom_range(0, 1));
        funct7 = ($urandom_range(0, 1) == 1) ? 7'b0011000 : 7'd0;
        rs1 = 5'($urandom_range(0, 1)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 1));
      end
      default: begin
        opcode = 5'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      end
    endcase
    mie  = 1'($urandom); meie = 1'($urandom); mtie = 1'($urandom); msie = 1'($urandom);
    meip = 1'($urandom); mtip = 1'($urandom); msip = 1'($urandom);
    finishCycle(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    model_phase = PH_RESET; model_cause = 0; model_i_or_e = 0; model_misaligned = 0;

    startCycle(); finishCycle(1'b0);
    startCycle(); finishCycle(1'b1);
    startCycle(); finishCycle(1'b1);

    startCycle(); illegal_instr = 1; misaligned_load = 1; finishCycle(1'b1);
    startCycle(); finishCycle(1'b1);
    checkOutput("illegal_cause", 32'(cause), 32'd2);

    startCycle(); opcode = 5'b11100; finishCycle(1'b1);
    startCycle(); finishCycle(1'b1);
    checkOutput("ecall_cause", 32'(cause), 32'd11);
    startCycle(); opcode = 5'b11100; rs2 = 5'd1; finishCycle(1'b1);
    startCycle(); finishCycle(1'b1);

    startCycle(); mie = 1; meie = 1; mtie = 1; meip = 1; mtip = 1; finishCycle(1'b1);
    startCycle(); finishCycle(1'b1);
    checkOutput("mei_kind", 32'(i_or_e), 32'd1);
    startCycle(); meie = 1; mtie = 1; meip = 1; mtip = 1; finishCycle(1'b1);

    startCycle(); opcode = 5'b11100; funct7 = 7'b0011000; rs2 = 5'd2;
    mie = 1; mtie = 1; mtip = 1; finishCycle(1'b1);
    startCycle(); finishCycle(1'b1);
    startCycle(); finishCycle(1'b1);

    startCycle(); misaligned_store = 1; finishCycle(1'b1);
    startCycle(); finishCycle(1'b0);
    checkOutput("reset_mid_trap_cause", 32'(cause), 32'd0);
    startCycle(); finishCycle(1'b1);
    startCycle(); finishCycle(1'b1);

    for (int n = 0; n < 600; n++) applyStimulus();
    startCycle(); finishCycle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
